instr_fetch_mem: RTL and testbench
==================================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, meaning instruction width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 8, meaning PC/address width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 16, meaning number of instruction words, with DEPTH <= 2**ADDR_W.
REQ-004 The block SHALL have port clk  input  1  sole clock, all logic on rising edge.
REQ-005 The block SHALL have port reset_n  input  1  synchronous, active-low reset.
REQ-006 The block SHALL have port prog_we  input  1  program-load write strobe.
REQ-007 The block SHALL have port prog_addr  input  ADDR_W  program-load word address.
REQ-008 The block SHALL have port prog_data  input  DATA_W  program-load word.
REQ-009 The block SHALL have port prog_ready  output  1  high when program writes are accepted.
REQ-010 The block SHALL have port pc_valid  input  1  fetch request valid.
REQ-011 The block SHALL have port pc_addr  input  ADDR_W  fetch address (PC).
REQ-012 The block SHALL have port pc_ready  output  1  fetch request accepted this cycle.
REQ-013 The block SHALL have port instr_valid  output  1  instr_data holds a fetched word.
REQ-014 The block SHALL have port instr_data  output  DATA_W  fetched instruction.
REQ-015 The block SHALL have port instr_ready  input  1  consumer accepts instr_data.
REQ-016 The block SHALL have port addr_err  output  1  fetched word came from address >= DEPTH.

Function
REQ-017 The FSM SHALL have states CLEAR, RUN; reset enters CLEAR.
REQ-018 In CLEAR, a counter SHALL write all-zero (NOP) to one word per cycle, addresses 0..DEPTH-1, then enter RUN the cycle after writing DEPTH-1 (DEPTH cycles total).
REQ-019 In CLEAR, prog_ready and pc_ready SHALL be 0; prog_we and pc_valid SHALL be ignored.
REQ-020 In RUN, prog_ready SHALL be 1; prog_we with prog_addr < DEPTH SHALL write prog_data that edge; prog_addr >= DEPTH SHALL be dropped silently.
REQ-021 In RUN, pc_ready SHALL equal (!instr_valid || instr_ready); a fetch is accepted when pc_valid && pc_ready.
REQ-022 An accepted fetch SHALL present instr_valid=1 and its word on instr_data on the next cycle (latency 1).
REQ-023 instr_valid, instr_data and addr_err SHALL hold stable while instr_valid && !instr_ready.
REQ-024 instr_valid SHALL fall the cycle after instr_valid && instr_ready when no new fetch is accepted; back-to-back accepted fetches SHALL sustain one word per cycle.
REQ-025 A fetch with pc_addr >= DEPTH SHALL return all-zero instr_data with addr_err=1; otherwise addr_err=0.
REQ-026 A write and an accepted fetch to the same address in the same cycle SHALL return the newly written prog_data (write-first bypass).
REQ-027 Address arithmetic SHALL use no wrap-around; pc_addr is used as given, unsigned.

Reset
REQ-028 On clk edge with reset_n=0: state=CLEAR, clear counter=0, instr_valid=0, instr_data=0, addr_err=0, prog_ready=0, pc_ready=0.
REQ-029 Reset asserted mid-CLEAR or mid-RUN SHALL restart CLEAR from address 0 and discard any pending instruction.
REQ-030 Memory contents SHALL be defined only via CLEAR; no reset of the array itself.

Configuration
REQ-031 With macro INSTR_FETCH_MEM_PARITY_EN defined, each word SHALL store an extra even-parity bit, written on CLEAR/program-load and checked on fetch; a mismatch SHALL drive output par_err=1 alongside instr_valid, and SHALL hold it under stall as REQ-023.
REQ-032 Without INSTR_FETCH_MEM_PARITY_EN, no parity storage exists and par_err SHALL be absent from the port list.

Structure
REQ-033 Shared package SHALL hold default DATA_W/ADDR_W/DEPTH constants, the NOP encoding (all zero) and the FSM state enum {CLEAR, RUN}.
REQ-034 The storage array SHALL be one sub-module, instr_ram (single write port, single async read port), with the FSM, bypass and output register in instr_fetch_mem.

Verification
REQ-035 Scenario: release reset, DEPTH=16 -> prog_ready/pc_ready low for 16 cycles, high on cycle 17; fetch of any address returns 0x00.
REQ-036 Scenario: write 0x30@1, 0x48@2, 0x81@3, fetch 1,2,3 back-to-back with instr_ready=1 -> instr_data 0x30,0x48,0x81 on consecutive cycles, instr_valid continuously 1.
REQ-037 Scenario: fetch 2, hold instr_ready=0 for 3 cycles -> instr_data stays 0x48, pc_ready=0; instr_ready=1 -> pc_ready=1 that cycle.
REQ-038 Scenario: fetch pc_addr=0x20 with DEPTH=16 -> instr_data=0x00, addr_err=1; write to 0x20 leaves words 0..15 unchanged.
REQ-039 Scenario: same-cycle write 0x55@5 and fetch 5 -> instr_data=0x55 next cycle.
REQ-040 Scenario: reset_n=0 for one cycle while instr_valid=1 -> instr_valid=0 next cycle, CLEAR restarts, word 1 reads 0x00 afterwards.

Source files
------------

// File: rtl/instr_fetch_mem_pkg.sv
// Shared constants, NOP encoding and FSM state type for the instruction fetch memory.
// Optional feature macro: INSTR_FETCH_MEM_PARITY_EN (per-word even parity).
package instr_fetch_mem_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DEPTH  = 16;

    // NOP is the all-zero word; wide enough to slice for any practical DATA_W.
    localparam int                    MAX_DATA_W = 64;
    localparam logic [MAX_DATA_W-1:0] NOP_WORD   = '0;

    // CLEAR initialises the array after reset, RUN serves loads and fetches.
    typedef enum logic {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_e;

endpackage

// File: rtl/instr_fetch_mem_if.sv
// Program-load and fetch bus of the instruction fetch memory.
// Optional feature macro: INSTR_FETCH_MEM_PARITY_EN adds par_err.
//
// Handshakes: a transfer happens on a rising edge where valid && ready are both
// high. The master may not depend on ready to raise valid. The instruction
// channel (instr_valid/instr_data/addr_err) holds stable while instr_valid is
// high and instr_ready is low. prog_we is a write strobe qualified by prog_ready.
interface instr_fetch_mem_if #(
    parameter int DATA_W = instr_fetch_mem_pkg::DEF_DATA_W,
    parameter int ADDR_W = instr_fetch_mem_pkg::DEF_ADDR_W
) ();
    logic              prog_we;
    logic [ADDR_W-1:0] prog_addr;
    logic [DATA_W-1:0] prog_data;
    logic              prog_ready;
    logic              pc_valid;
    logic [ADDR_W-1:0] pc_addr;
    logic              pc_ready;
    logic              instr_valid;
    logic [DATA_W-1:0] instr_data;
    logic              instr_ready;
    logic              addr_err;
`ifdef INSTR_FETCH_MEM_PARITY_EN
    logic              par_err;
`endif

    modport master (
        output prog_we, prog_addr, prog_data, pc_valid, pc_addr, instr_ready,
        input  prog_ready, pc_ready, instr_valid, instr_data, addr_err
`ifdef INSTR_FETCH_MEM_PARITY_EN
        , input par_err
`endif
    );

    modport slave (
        input  prog_we, prog_addr, prog_data, pc_valid, pc_addr, instr_ready,
        output prog_ready, pc_ready, instr_valid, instr_data, addr_err
`ifdef INSTR_FETCH_MEM_PARITY_EN
        , output par_err
`endif
    );

endinterface

// File: rtl/instr_fetch_mem_ram.sv
// instr_ram: plain storage array, one synchronous write port, one async read port.
// Contents are never reset; the fetch FSM initialises them.
module instr_ram #(
    parameter int WORD_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     waddr_i,
    input  logic [WORD_W-1:0] wdata_i,
    input  logic [AW-1:0]     raddr_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH];

    // Single write port.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_mem.sv
// Instruction fetch memory: clears the array after reset, then accepts program
// loads and serves fetches with one cycle latency and write-first bypass.
// Optional feature macro: INSTR_FETCH_MEM_PARITY_EN (even parity per word, par_err).
module instr_fetch_mem
    import instr_fetch_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input  logic               clk,
    input  logic               reset_n,
    instr_fetch_mem_if.slave   bus,
    output state_e             dbg_state_o
);

    localparam int RAM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef INSTR_FETCH_MEM_PARITY_EN
    localparam int WORD_W = DATA_W + 1;
`else
    localparam int WORD_W = DATA_W;
`endif
    localparam logic [ADDR_W:0]   DEPTH_X  = (ADDR_W + 1)'(DEPTH);
    localparam logic [RAM_AW-1:0] LAST_IDX = RAM_AW'(DEPTH - 1);
    localparam logic [DATA_W-1:0] NOP      = NOP_WORD[DATA_W-1:0];

    state_e              state_q, state_d;
    logic [RAM_AW-1:0]   clr_cnt_q, clr_cnt_d;
    logic                instr_valid_q, instr_valid_d;
    logic [DATA_W-1:0]   instr_data_q, instr_data_d;
    logic                addr_err_q, addr_err_d;
    logic                par_err_q, par_err_d;

    logic                run;
    logic                pc_ready;
    logic                fetch_acc;
    logic                prog_in_range;
    logic                pc_in_range;
    logic                prog_acc;
    logic                bypass;
    logic [WORD_W-1:0]   clear_word;
    logic [WORD_W-1:0]   prog_word;
    logic [WORD_W-1:0]   fetch_word;
    logic                ram_we;
    logic [RAM_AW-1:0]   ram_waddr;
    logic [WORD_W-1:0]   ram_wdata;
    logic [WORD_W-1:0]   ram_rdata;

    // Addresses are compared unsigned and untruncated; nothing wraps.
    assign prog_in_range = ({1'b0, bus.prog_addr} < DEPTH_X);
    assign pc_in_range   = ({1'b0, bus.pc_addr} < DEPTH_X);

    assign run       = (state_q == RUN);
    assign pc_ready  = run && (!instr_valid_q || bus.instr_ready);
    assign fetch_acc = bus.pc_valid && pc_ready;
    assign prog_acc  = run && bus.prog_we && prog_in_range;
    assign bypass    = prog_acc && (bus.prog_addr == bus.pc_addr);

`ifdef INSTR_FETCH_MEM_PARITY_EN
    // Stored word is {parity, data}; the parity bit makes the total count of ones even.
    assign clear_word = {1'b0, NOP};
    assign prog_word  = {^bus.prog_data, bus.prog_data};
`else
    assign clear_word = NOP;
    assign prog_word  = bus.prog_data;
`endif

    assign fetch_word = bypass ? prog_word : ram_rdata;

    // State and clear-counter registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= CLEAR;
            clr_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
        end
    end

    // Next state: walk the clear counter over every word, then serve requests.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            CLEAR: begin
                if (clr_cnt_q == LAST_IDX) begin
                    state_d   = RUN;
                    clr_cnt_d = '0;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
    end

    // Write port arbitration: clear sweep owns the port in CLEAR, program loads in RUN.
    always_comb begin
        ram_we    = 1'b0;
        ram_waddr = clr_cnt_q;
        ram_wdata = clear_word;
        if (reset_n) begin
            if (state_q == CLEAR) begin
                ram_we = 1'b1;
            end else if (prog_acc) begin
                ram_we    = 1'b1;
                ram_waddr = bus.prog_addr[RAM_AW-1:0];
                ram_wdata = prog_word;
            end
        end
    end

    instr_ram #(
        .WORD_W (WORD_W),
        .DEPTH  (DEPTH),
        .AW     (RAM_AW)
    ) u_ram (
        .clk     (clk),
        .we_i    (ram_we),
        .waddr_i (ram_waddr),
        .wdata_i (ram_wdata),
        .raddr_i (bus.pc_addr[RAM_AW-1:0]),
        .rdata_o (ram_rdata)
    );

    // Output register next value: load on accepted fetch, drop valid once consumed, else hold.
    always_comb begin
        instr_valid_d = instr_valid_q;
        instr_data_d  = instr_data_q;
        addr_err_d    = addr_err_q;
        par_err_d     = par_err_q;
        if (fetch_acc) begin
            instr_valid_d = 1'b1;
            if (pc_in_range) begin
                instr_data_d = fetch_word[DATA_W-1:0];
                addr_err_d   = 1'b0;
                par_err_d    = ^fetch_word;
            end else begin
                instr_data_d = NOP;
                addr_err_d   = 1'b1;
                par_err_d    = 1'b0;
            end
        end else if (bus.instr_ready) begin
            instr_valid_d = 1'b0;
        end
    end

    // Output register; reset discards any pending instruction.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            instr_valid_q <= 1'b0;
            instr_data_q  <= '0;
            addr_err_q    <= 1'b0;
            par_err_q     <= 1'b0;
        end else begin
            instr_valid_q <= instr_valid_d;
            instr_data_q  <= instr_data_d;
            addr_err_q    <= addr_err_d;
            par_err_q     <= par_err_d;
        end
    end

    assign bus.prog_ready  = run;
    assign bus.pc_ready    = pc_ready;
    assign bus.instr_valid = instr_valid_q;
    assign bus.instr_data  = instr_data_q;
    assign bus.addr_err    = addr_err_q;
`ifdef INSTR_FETCH_MEM_PARITY_EN
    assign bus.par_err     = par_err_q;
`else
    logic unused_par;
    assign unused_par = par_err_q;
`endif
    assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_instr_fetch_mem.sv
// Bench for instr_fetch_mem: directed scenarios plus a randomized run against a
// queue-based reference model of the memory and instruction channel.
module tb_instr_fetch_mem;
    import instr_fetch_mem_pkg::*;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 8;
    localparam int DEPTH  = 16;

    logic   clk     = 1'b0;
    logic   reset_n = 1'b0;
    state_e dbg_state;

    int n_vec = 0;
    int n_err = 0;

    logic [DATA_W-1:0] model_mem [DEPTH];
    logic [DATA_W:0]   exp_q [$];

    instr_fetch_mem_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    instr_fetch_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .bus         (bus),
        .dbg_state_o (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.prog_we     = 1'b0;
        bus.prog_addr   = '0;
        bus.prog_data   = '0;
        bus.pc_valid    = 1'b0;
        bus.pc_addr     = '0;
        bus.instr_ready = 1'b1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        drive_idle();
        bus.pc_valid = 1'b1;
        reset_n = 1'b0;
        repeat (3) tick();
        n_vec++;
        if (bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL reset_instr_valid got=%b exp=0", bus.instr_valid);
        end
        n_vec++;
        if (bus.instr_data !== 8'h00) begin
            n_err++; $display("FAIL reset_instr_data got=%h exp=00", bus.instr_data);
        end
        n_vec++;
        if (bus.addr_err !== 1'b0) begin
            n_err++; $display("FAIL reset_addr_err got=%b exp=0", bus.addr_err);
        end
        n_vec++;
        if (bus.prog_ready !== 1'b0 || bus.pc_ready !== 1'b0) begin
            n_err++; $display("FAIL reset_ready got=%b%b exp=00", bus.prog_ready, bus.pc_ready);
        end
        n_vec++;
        if (dbg_state !== CLEAR) begin
            n_err++; $display("FAIL reset_state got=%0d exp=%0d", dbg_state, CLEAR);
        end
    endtask

    task automatic test_clear();
        // Stray requests during CLEAR must be ignored.
        bus.pc_valid  = 1'b1;
        bus.pc_addr   = 8'd7;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'd7;
        bus.prog_data = 8'hFF;
        reset_n = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            n_vec++;
            if (bus.prog_ready !== 1'b0 || bus.pc_ready !== 1'b0 || bus.instr_valid !== 1'b0) begin
                n_err++;
                $display("FAIL clear_busy cycle=%0d got prog_ready=%b pc_ready=%b instr_valid=%b exp=0,0,0",
                         i, bus.prog_ready, bus.pc_ready, bus.instr_valid);
            end
            tick();
        end
        bus.prog_we = 1'b0;
        bus.pc_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.prog_ready !== 1'b1 || bus.pc_ready !== 1'b1) begin
            n_err++; $display("FAIL clear_done_ready got=%b%b exp=11", bus.prog_ready, bus.pc_ready);
        end
        n_vec++;
        if (dbg_state !== RUN) begin
            n_err++; $display("FAIL clear_done_state got=%0d exp=%0d", dbg_state, RUN);
        end
        model_clear();
        // Every word reads as NOP after the sweep.
        bus.pc_valid = 1'b1;
        bus.instr_ready = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.pc_addr = 8'(a);
            tick();
            n_vec++;
            if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h00 || bus.addr_err !== 1'b0) begin
                n_err++;
                $display("FAIL clear_word addr=%0d got v=%b d=%h e=%b exp v=1 d=00 e=0",
                         a, bus.instr_valid, bus.instr_data, bus.addr_err);
            end
        end
        bus.pc_valid = 1'b0;
        tick();
    endtask

    task automatic test_program_fetch();
        logic [7:0] wa [3];
        logic [7:0] wd [3];
        wa = '{8'd1, 8'd2, 8'd3};
        wd = '{8'h30, 8'h48, 8'h81};
        drive_idle();
        for (int i = 0; i < 3; i++) begin
            bus.prog_we   = 1'b1;
            bus.prog_addr = wa[i];
            bus.prog_data = wd[i];
            model_mem[wa[i]] = wd[i];
            tick();
        end
        bus.prog_we = 1'b0;
        bus.pc_valid = 1'b1;
        bus.instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_addr = wa[i];
            tick();
            n_vec++;
            if (bus.instr_valid !== 1'b1 || bus.instr_data !== wd[i]) begin
                n_err++;
                $display("FAIL b2b_fetch idx=%0d got v=%b d=%h exp v=1 d=%h",
                         i, bus.instr_valid, bus.instr_data, wd[i]);
            end
        end
        bus.pc_valid = 1'b0;
        tick();
        n_vec++;
        if (bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL b2b_valid_fall got=%b exp=0", bus.instr_valid);
        end
    endtask

    task automatic test_stall();
        drive_idle();
        bus.pc_valid = 1'b1;
        bus.pc_addr  = 8'd2;
        tick();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h48) begin
            n_err++; $display("FAIL stall_first got v=%b d=%h exp v=1 d=48", bus.instr_valid, bus.instr_data);
        end
        bus.pc_addr = 8'd3;
        bus.instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if (bus.pc_ready !== 1'b0) begin
                n_err++; $display("FAIL stall_pc_ready cycle=%0d got=%b exp=0", i, bus.pc_ready);
            end
            tick();
            n_vec++;
            if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h48 || bus.addr_err !== 1'b0) begin
                n_err++;
                $display("FAIL stall_hold cycle=%0d got v=%b d=%h e=%b exp v=1 d=48 e=0",
                         i, bus.instr_valid, bus.instr_data, bus.addr_err);
            end
        end
        bus.instr_ready = 1'b1;
        bus.pc_valid = 1'b0;
        #1;
        n_vec++;
        if (bus.pc_ready !== 1'b1) begin
            n_err++; $display("FAIL stall_release_ready got=%b exp=1", bus.pc_ready);
        end
        tick();
        n_vec++;
        if (bus.instr_valid !== 1'b0) begin
            n_err++; $display("FAIL stall_release_valid got=%b exp=0", bus.instr_valid);
        end
    endtask

    task automatic test_addr_err();
        drive_idle();
        bus.pc_valid = 1'b1;
        bus.pc_addr  = 8'h20;
        tick();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h00 || bus.addr_err !== 1'b1) begin
            n_err++;
            $display("FAIL oor_fetch got v=%b d=%h e=%b exp v=1 d=00 e=1",
                     bus.instr_valid, bus.instr_data, bus.addr_err);
        end
        bus.pc_valid  = 1'b0;
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'h20;
        bus.prog_data = 8'hAA;
        tick();
        bus.prog_we  = 1'b0;
        bus.pc_valid = 1'b1;
        for (int a = 0; a < DEPTH; a++) begin
            bus.pc_addr = 8'(a);
            tick();
            n_vec++;
            if (bus.instr_data !== model_mem[a] || bus.addr_err !== 1'b0) begin
                n_err++;
                $display("FAIL oor_write_untouched addr=%0d got d=%h e=%b exp d=%h e=0",
                         a, bus.instr_data, bus.addr_err, model_mem[a]);
            end
        end
        bus.pc_addr = 8'hFF;
        tick();
        n_vec++;
        if (bus.instr_data !== 8'h00 || bus.addr_err !== 1'b1) begin
            n_err++; $display("FAIL oor_top_addr got d=%h e=%b exp d=00 e=1", bus.instr_data, bus.addr_err);
        end
        bus.pc_valid = 1'b0;
        tick();
    endtask

    task automatic test_bypass();
        drive_idle();
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'd5;
        bus.prog_data = 8'h55;
        bus.pc_valid  = 1'b1;
        bus.pc_addr   = 8'd5;
        model_mem[5]  = 8'h55;
        tick();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h55) begin
            n_err++; $display("FAIL bypass got v=%b d=%h exp v=1 d=55", bus.instr_valid, bus.instr_data);
        end
        drive_idle();
        tick();
    endtask

    task automatic test_random();
        int  pa, ca, pd;
        logic pw, pv, ir, exp_ready;
        drive_idle();
        tick();
        exp_q.delete();
        for (int c = 0; c < 400; c++) begin
            pw = 1'($urandom_range(0, 1));
            pa = $urandom_range(0, 19);
            pd = $urandom_range(0, 255);
            pv = ($urandom_range(0, 9) < 7);
            ca = ($urandom_range(0, 9) < 2) ? pa : $urandom_range(0, 19);
            ir = ($urandom_range(0, 9) < 7);
            bus.prog_we     = pw;
            bus.prog_addr   = 8'(pa);
            bus.prog_data   = 8'(pd);
            bus.pc_valid    = pv;
            bus.pc_addr     = 8'(ca);
            bus.instr_ready = ir;
            #1;
            exp_ready = (exp_q.size() == 0) || ir;
            n_vec++;
            if (bus.pc_ready !== exp_ready) begin
                n_err++; $display("FAIL rand_pc_ready cycle=%0d got=%b exp=%b", c, bus.pc_ready, exp_ready);
            end
            if (ir && exp_q.size() != 0) void'(exp_q.pop_front());
            if (pw && pa < DEPTH) model_mem[pa] = 8'(pd);
            if (pv && exp_ready) begin
                if (ca < DEPTH) exp_q.push_back({1'b0, model_mem[ca]});
                else            exp_q.push_back({1'b1, 8'h00});
            end
            tick();
            n_vec++;
            if (bus.instr_valid !== (exp_q.size() != 0)) begin
                n_err++;
                $display("FAIL rand_valid cycle=%0d got=%b exp=%b", c, bus.instr_valid, exp_q.size() != 0);
            end else if (exp_q.size() != 0) begin
                n_vec++;
                if ({bus.addr_err, bus.instr_data} !== exp_q[0]) begin
                    n_err++;
                    $display("FAIL rand_word cycle=%0d got e=%b d=%h exp e=%b d=%h",
                             c, bus.addr_err, bus.instr_data, exp_q[0][DATA_W], exp_q[0][DATA_W-1:0]);
                end
`ifdef INSTR_FETCH_MEM_PARITY_EN
                n_vec++;
                if (bus.par_err !== 1'b0) begin
                    n_err++; $display("FAIL rand_par_err cycle=%0d got=%b exp=0", c, bus.par_err);
                end
`endif
            end
        end
        bus.pc_valid = 1'b0;
        bus.prog_we  = 1'b0;
        bus.instr_ready = 1'b1;
        tick();
    endtask

    task automatic test_reset_mid();
        int cyc;
        drive_idle();
        bus.prog_we   = 1'b1;
        bus.prog_addr = 8'd1;
        bus.prog_data = 8'h30;
        tick();
        bus.prog_we = 1'b0;
        bus.pc_valid = 1'b1;
        bus.pc_addr  = 8'd1;
        bus.instr_ready = 1'b0;
        tick();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== 8'h30) begin
            n_err++; $display("FAIL rmid_pending got v=%b d=%h exp v=1 d=30", bus.instr_valid, bus.instr_data);
        end
        bus.pc_valid = 1'b0;
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        n_vec++;
        if (bus.instr_valid !== 1'b0 || bus.instr_data !== 8'h00 || bus.prog_ready !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_discard got v=%b d=%h pr=%b exp v=0 d=00 pr=0",
                     bus.instr_valid, bus.instr_data, bus.prog_ready);
        end
        // Interrupt the sweep partway; it must restart from the beginning.
        repeat (5) tick();
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        cyc = 0;
        while (bus.prog_ready !== 1'b1 && cyc < 40) begin
            tick();
            cyc++;
        end
        n_vec++;
        if (cyc != DEPTH) begin
            n_err++; $display("FAIL rmid_clear_len got=%0d exp=%0d", cyc, DEPTH);
        end
        model_clear();
        bus.instr_ready = 1'b1;
        bus.pc_valid = 1'b1;
        bus.pc_addr  = 8'd1;
        tick();
        n_vec++;
        if (bus.instr_valid !== 1'b1 || bus.instr_data !== model_mem[1]) begin
            n_err++;
            $display("FAIL rmid_word1 got v=%b d=%h exp v=1 d=%h", bus.instr_valid, bus.instr_data, model_mem[1]);
        end
        drive_idle();
        tick();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        drive_idle();
        test_reset();
        test_clear();
        test_program_fetch();
        test_stall();
        test_addr_err();
        test_bypass();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
